// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM slave's FSM state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

   // Output values each state presents on the bus.
   function automatic logic state_ready(slave_state_e s);
      return !(s inside {ST_WAIT, ST_ERR1});
   endfunction

   function automatic logic state_resp(slave_state_e s);
      return (s inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
   endfunction

endpackage

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite slave-port bundle: address/data-phase inputs and the slave response.
interface ahb_ram_slave_if;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahb_lane_decode.sv
// Byte-lane strobes and legality check for one transfer from (hsize, addr[1:0]).
module ahb_lane_decode
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   output logic [3:0] strobe,
   output logic       misaligned
);

   // Oversized transfers are flagged as misaligned too: both end in ERROR.
   always_comb begin
      strobe     = 4'b0000;
      misaligned = 1'b0;
      case (hsize)
         HSIZE_BYTE: strobe = 4'b0001 << addr;
         HSIZE_HALF: begin
            strobe     = 4'b0011 << addr;
            misaligned = addr[0];
         end
         HSIZE_WORD: begin
            strobe     = 4'b1111;
            misaligned = |addr;
         end
         default:    misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave: configurable wait states, byte-enabled word memory,
// two-cycle ERROR response for misaligned or oversized accesses.
module ahb_ram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 1
) (
   input logic            hclk,
   input logic            hresetn,
   ahb_ram_slave_if.slave bus
);

   localparam int WORDS = 2 ** (ADDR_W - 2);
   localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   slave_state_e      state;
   slave_state_e      accept_state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-3:0] word_q;
   logic              write_q;
   logic [3:0]        strb_q;
   logic [31:0]       mem [WORDS];
   logic              accept;
   logic              misaligned;
   logic [3:0]        strobe;
   logic [31:0]       lane_mask;
   logic              unused_bits;

   ahb_lane_decode u_lane_decode (
      .hsize      (bus.hsize),
      .addr       (bus.haddr[1:0]),
      .strobe     (strobe),
      .misaligned (misaligned)
   );

   assign accept      = bus.hsel && bus.htrans[1] && bus.hready;
   assign unused_bits = &{1'b0, bus.hprot, bus.haddr[31:ADDR_W]};

   always_comb begin
      accept_state = ST_IDLE;
      if (accept) begin
         if (misaligned)           accept_state = ST_ERR1;
         else if (WAIT_STATES > 0) accept_state = ST_WAIT;
         else                      accept_state = ST_DATA;
      end
   end

   // NOTE: state and outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state         <= ST_IDLE;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= HRESP_OKAY;
         wait_cnt      <= '0;
         word_q        <= '0;
         write_q       <= 1'b0;
         strb_q        <= '0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  state         <= ST_DATA;
                  bus.hreadyout <= state_ready(ST_DATA);
                  bus.hresp     <= state_resp(ST_DATA);
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_ERR1: begin
               state         <= ST_ERR2;
               bus.hreadyout <= state_ready(ST_ERR2);
               bus.hresp     <= state_resp(ST_ERR2);
            end
            // IDLE, DATA and ERR2 all sample the bus for the next transfer.
            default: begin
               state         <= accept_state;
               bus.hreadyout <= state_ready(accept_state);
               bus.hresp     <= state_resp(accept_state);
               wait_cnt      <= CNT_W'(WAIT_STATES - 1);
               if (accept) begin
                  word_q  <= bus.haddr[ADDR_W-1:2];
                  write_q <= bus.hwrite;
                  strb_q  <= strobe;
               end
            end
         endcase
      end
   end

   // NOTE: the RAM array has no reset; its contents are undefined until written.
   always_ff @(posedge hclk) begin
      if (state == ST_DATA && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) mem[word_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
         end
      end
   end

   // Reads see any write committed at the edge that opened this data phase.
   assign lane_mask  = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
   assign bus.hrdata = (state == ST_DATA && !write_q) ? (mem[word_q] & lane_mask) : '0;

endmodule
